// File: rtl/mult_share_arb_if.sv
// Request/response bundle for mult_share_arb: NREQ operand-pair requesters in,
// one tagged product stream out.
//
// Handshake rule for every valid/ready pair in this bundle:
//   - A transfer happens on a rising clk edge where valid && ready are both high.
//   - valid never depends combinationally on ready.
//   - Once valid is raised, it and its payload stay unchanged until the transfer.
interface mult_share_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [16*NREQ-1:0]   req_a;
  logic [16*NREQ-1:0]   req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_product;

  // Requesters and the response consumer.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product
  );

  // The arbiter.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product
  );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one external combinational 16x16 multiplier among
// NREQ requesters. Define MULT_SHARE_ARB_SKID_EN for a 2-entry output skid FIFO.
module mult_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  mult_share_arb_if.slave bus,
  output logic [15:0]     mul_a,
  output logic [15:0]     mul_b,
  input  logic [31:0]     mul_p,
  output logic [IDW-1:0]  dbg_rr_ptr,
  output logic [1:0]      dbg_count
);

  localparam logic [IDW:0]   NREQ_W   = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  logic [IDW-1:0]    rr_ptr;
  logic [2*NREQ-1:0] req_dbl;
  logic [2*NREQ-1:0] req_shift;
  logic [NREQ-1:0]   req_rot;
  logic              grant_found;
  logic [IDW:0]      grant_sum;
  logic [IDW-1:0]    grant_idx;
  logic              slot_free;
  logic              accept;

  // Rotating a doubled copy puts index rr_ptr at bit 0, so the first set bit
  // of req_rot is the round-robin winner, offset from rr_ptr.
  assign req_dbl   = {bus.req_valid, bus.req_valid};
  assign req_shift = req_dbl >> rr_ptr;
  assign req_rot   = req_shift[NREQ-1:0];

  always_comb begin
    grant_found = 1'b0;
    grant_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && req_rot[k]) begin
        grant_found = 1'b1;
        grant_sum   = {1'b0, rr_ptr} + (IDW+1)'(k);
      end
    end
    if (grant_sum >= NREQ_W) begin
      grant_sum = grant_sum - NREQ_W;
    end
    grant_idx = grant_sum[IDW-1:0];
  end

  always_comb begin
    mul_a = 16'h0000;
    mul_b = 16'h0000;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_found && (grant_idx == IDW'(i))) begin
        mul_a = bus.req_a[16*i +: 16];
        mul_b = bus.req_b[16*i +: 16];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = !rst && slot_free && grant_found && (grant_idx == IDW'(i));
    end
  end

  // The granted requester is valid by construction, so accept needs no req_valid term.
  assign accept = !rst && slot_free && grant_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDW'(1);
    end
  end

  assign dbg_rr_ptr = rr_ptr;

`ifdef MULT_SHARE_ARB_SKID_EN

  logic [IDW-1:0] id_mem   [2];
  logic [31:0]    prod_mem [2];
  logic           wr_ptr;
  logic           rd_ptr;
  logic [1:0]     fifo_count;
  logic [1:0]     count_next;
  logic           fifo_full_q;
  logic           push;
  logic           pop;

  // slot_free comes only from a flop, so req_ready never sees rsp_ready.
  assign slot_free = !fifo_full_q;
  assign push      = accept;
  assign pop       = (fifo_count != 2'd0) && bus.rsp_ready;

  always_comb begin
    count_next = fifo_count;
    case ({push, pop})
      2'b10:   count_next = fifo_count + 2'd1;
      2'b01:   count_next = fifo_count - 2'd1;
      default: count_next = fifo_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
      fifo_full_q <= 1'b0;
      for (int e = 0; e < 2; e++) begin
        id_mem[e]   <= '0;
        prod_mem[e] <= '0;
      end
    end else begin
      if (push) begin
        id_mem[wr_ptr]   <= grant_idx;
        prod_mem[wr_ptr] <= mul_p;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_count  <= count_next;
      fifo_full_q <= (count_next == 2'd2);
    end
  end

  assign bus.rsp_valid   = (fifo_count != 2'd0);
  assign bus.rsp_id      = id_mem[rd_ptr];
  assign bus.rsp_product = prod_mem[rd_ptr];
  assign dbg_count       = fifo_count;

`else

  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [31:0]    rsp_product_q;

  assign slot_free = !rsp_valid_q || bus.rsp_ready;

  // A new accept overwrites a result being consumed in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
    end else if (accept) begin
      rsp_valid_q   <= 1'b1;
      rsp_id_q      <= grant_idx;
      rsp_product_q <= mul_p;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_product = rsp_product_q;
  assign dbg_count       = {1'b0, rsp_valid_q};

`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb: reset, round robin, table-driven arbitration
// and arithmetic vectors, backpressure and mid-operation reset.
`timescale 1ns/1ps
module tb_mult_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = IDW + 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [15:0]    mul_a;
  logic [15:0]    mul_b;
  logic [31:0]    mul_p;
  logic [IDW-1:0] dbg_rr_ptr;
  logic [1:0]     dbg_count;

  mult_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mult_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p),
    .dbg_rr_ptr (dbg_rr_ptr),
    .dbg_count  (dbg_count)
  );

  // The shared multiplier that sits beside the arbiter.
  assign mul_p = 32'(mul_a) * 32'(mul_b);

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {bus.rsp_id, bus.rsp_product}, 64'h0);
        end else begin
          check("rsp", {bus.rsp_id, bus.rsp_product}, exp_q.pop_front());
        end
      end
      check("ready_onehot", ($countones(bus.req_ready) <= 1), 1);
      check("ready_subset", bus.req_ready & ~bus.req_valid, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] valid, input logic [63:0] a, input logic [63:0] b);
    bus.req_valid = valid;
    bus.req_a     = a;
    bus.req_b     = b;
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      tick();
      #1;
      n++;
    end
    check("grant_timeout", (n < 20), 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0]     valid;
    logic [63:0]    a;
    logic [63:0]    b;
    logic [IDW-1:0] exp_id;
    logic [31:0]    exp_p;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic [3:0] valid,
                              logic [15:0] a3, logic [15:0] a2, logic [15:0] a1, logic [15:0] a0,
                              logic [15:0] b3, logic [15:0] b2, logic [15:0] b1, logic [15:0] b0,
                              logic [IDW-1:0] id, logic [31:0] p);
    vec_t v;
    v.valid  = valid;
    v.a      = {a3, a2, a1, a0};
    v.b      = {b3, b2, b1, b0};
    v.exp_id = id;
    v.exp_p  = p;
    return v;
  endfunction

  logic [31:0] rr_prod[4];
  logic [3:0]  exp_ready;

  initial begin
    // rr_ptr == 1 when the table starts; each row notes the pointer it sees.
    vecs[0]  = mk(4'b0100, 16'h0, 16'd300, 16'h0, 16'h0,    16'h0, 16'd7, 16'h0, 16'h0,       2'd2, 32'd2100);    // rr=1
    vecs[1]  = mk(4'b0001, 16'h0, 16'h0, 16'h0, 16'hFFFF,    16'h0, 16'h0, 16'h0, 16'hFFFF,    2'd0, 32'hFFFE0001); // rr=3
    vecs[2]  = mk(4'b1000, 16'h0, 16'h0, 16'h0, 16'h0,       16'hFFFF, 16'h0, 16'h0, 16'h0,    2'd3, 32'h0);       // rr=1
    vecs[3]  = mk(4'b1010, 16'h8000, 16'h0, 16'd1234, 16'h0, 16'd2, 16'h0, 16'd5678, 16'h0,    2'd1, 32'h006AE9BC); // rr=0
    vecs[4]  = mk(4'b1001, 16'h8000, 16'h0, 16'h0, 16'h0100, 16'd2, 16'h0, 16'h0, 16'h0100,    2'd3, 32'h00010000); // rr=2
    vecs[5]  = mk(4'b0101, 16'h0, 16'd3, 16'h0, 16'h0100,    16'h0, 16'd5, 16'h0, 16'h0100,    2'd0, 32'h00010000); // rr=0
    vecs[6]  = mk(4'b0110, 16'h0, 16'd3, 16'hFFFF, 16'h0,    16'h0, 16'd5, 16'd1, 16'h0,       2'd1, 32'h0000FFFF); // rr=1
    vecs[7]  = mk(4'b0100, 16'h0, 16'd3, 16'h0, 16'h0,       16'h0, 16'd5, 16'h0, 16'h0,       2'd2, 32'd15);      // rr=2
    vecs[8]  = mk(4'b0111, 16'h0, 16'h1111, 16'd2, 16'd7,   16'h0, 16'h000F, 16'd2, 16'd9,    2'd0, 32'd63);      // rr=3
    vecs[9]  = mk(4'b0110, 16'h0, 16'h1111, 16'd2, 16'h0,   16'h0, 16'h000F, 16'd2, 16'h0,    2'd1, 32'd4);       // rr=1
    vecs[10] = mk(4'b0100, 16'h0, 16'h1111, 16'h0, 16'h0,   16'h0, 16'h000F, 16'h0, 16'h0,    2'd2, 32'h0000FFFF); // rr=2

    rr_prod[0] = 32'h0000FFFF;
    rr_prod[1] = 32'h0001FFFE;
    rr_prod[2] = 32'h0002FFFD;
    rr_prod[3] = 32'h0003FFFC;

    // ---- reset with every requester valid ----
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    drive(4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, {4{16'hFFFF}});
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",   bus.req_ready, 0);
    check("rst_rsp_valid",   bus.rsp_valid, 0);
    check("rst_rsp_product", bus.rsp_product, 0);
    check("rst_rsp_id",      bus.rsp_id, 0);
    check("rst_rr_ptr",      dbg_rr_ptr, 0);

    // ---- round robin, all four continuously valid ----
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    check("first_grant", bus.req_ready, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      exp_ready = 4'(1 << (k % 4));
      check("rr_grant", bus.req_ready, exp_ready);
      exp_q.push_back({IDW'(k % 4), rr_prod[k % 4]});
      tick();
      #1;
    end

    // ---- table: one accept per row, back to back ----
    for (int r = 0; r < 11; r++) begin
      drive(vecs[r].valid, vecs[r].a, vecs[r].b);
      #1;
      wait_grant();
      exp_ready = 4'(1 << vecs[r].exp_id);
      check("tbl_grant", bus.req_ready, exp_ready);
      exp_q.push_back({vecs[r].exp_id, vecs[r].exp_p});
      tick();
    end

    // ---- backpressure ----
    drive(4'b0001, {16'h0, 16'h0, 16'h0, 16'h00AB}, {16'h0, 16'h0, 16'h0, 16'h0100});
    #1;
    check("bp_setup_grant", bus.req_ready, 4'b0001);
    exp_q.push_back({2'd0, 32'h0000AB00});
    tick();
    bus.rsp_ready = 1'b0;
    drive(4'b1010, {16'hFFFF, 16'h0, 16'h0010, 16'h0}, {16'hFFFF, 16'h0, 16'h0010, 16'h0});
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_req_ready",   bus.req_ready, 0);
      check("bp_rsp_valid",   bus.rsp_valid, 1);
      check("bp_rsp_id",      bus.rsp_id, 0);
      check("bp_rsp_product", bus.rsp_product, 32'h0000AB00);
      check("bp_rr_ptr",      dbg_rr_ptr, 1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_resume_grant", bus.req_ready, 4'b0010);
    exp_q.push_back({2'd1, 32'h00000100});
    tick();
    drive(4'b1000, {16'hFFFF, 16'h0, 16'h0010, 16'h0}, {16'hFFFF, 16'h0, 16'h0010, 16'h0});
    #1;
    check("bp_next_grant", bus.req_ready, 4'b1000);
    exp_q.push_back({2'd3, 32'hFFFE0001});
    tick();
    drive(4'b0000, 64'h0, 64'h0);
    #1;
    check("idle_mul_a", mul_a, 0);
    check("idle_mul_b", mul_b, 0);
    tick();

    // ---- reset while a result is held ----
    drive(4'b0100, {16'h0, 16'd5, 16'h0, 16'h0}, {16'h0, 16'd5, 16'h0, 16'h0});
    #1;
    check("mid_grant", bus.req_ready, 4'b0100);
    tick();
    drive(4'b0000, 64'h0, 64'h0);
    bus.rsp_ready = 1'b0;
    #1;
    check("mid_rsp_valid",   bus.rsp_valid, 1);
    check("mid_rsp_id",      bus.rsp_id, 2);
    check("mid_rsp_product", bus.rsp_product, 32'd25);
    #1;
    rst = 1'b1;
    #1;
    check("async_rsp_valid",   bus.rsp_valid, 0);
    check("async_rsp_product", bus.rsp_product, 0);
    check("async_rsp_id",      bus.rsp_id, 0);
    check("async_rr_ptr",      dbg_rr_ptr, 0);
    bus.rsp_ready = 1'b1;
    drive(4'b1111, 64'h0, 64'h0);
    #1;
    check("async_req_ready", bus.req_ready, 0);
    tick();
    drive(4'b0000, 64'h0, 64'h0);
    rst = 1'b0;
    repeat (4) tick();
    check("post_rst_rsp_valid", bus.rsp_valid, 0);
    check("post_rst_count",     dbg_count, 0);
    check("exp_q_empty",        exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Round-robin arbiter sharing one combinational 16x16 unsigned multiplier among NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block drives the granted operands into the multiplier and registers the 32-bit product.
- It returns the product on a single response channel, tagged with the requester index.
- The multiplier instance sits beside this block, wired through the mul_* ports.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of the requester index tag; must satisfy 2**IDW >= NREQ

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_a  in  16*NREQ  flattened multiplier operands; requester i uses bits [16*i+15:16*i]
- req_b  in  16*NREQ  flattened multiplicand operands; same packing
- mul_a  out  16  operand A to the shared multiplier
- mul_b  out  16  operand B to the shared multiplier
- mul_p  in  32  product from the shared multiplier (combinational)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  index of the requester that owns the response
- rsp_product  out  32  registered product

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid=0, rsp_id=0, rsp_product=0, rr_ptr=0.
  - req_ready=0 while rst is high.
  - Any in-flight result is discarded; no response appears after reset.
- Slot free: slot_free = !rsp_valid || rsp_ready (base build).
- Arbitration (combinational, each cycle):
  - Search req_valid starting at index rr_ptr, ascending, wrapping at NREQ-1 -> 0.
  - The first set bit is the grant g.
  - If slot_free and a grant exists: req_ready[g]=1, all other bits 0.
  - Otherwise req_ready is all zero.
- Multiplier drive:
  - mul_a/mul_b = operands of g when a grant exists; otherwise 16'h0000.
  - No operand registering.
- Accept: req_valid[g] && req_ready[g] at a rising edge causes:
  - rsp_product <= mul_p, rsp_id <= g, rsp_valid <= 1.
  - rr_ptr <= (g==NREQ-1) ? 0 : g+1.
- Latency: exactly 1 cycle from accept edge to rsp_valid high.
- Throughput: one accept per cycle while rsp_ready stays high.
- Response handshake:
  - rsp_valid && rsp_ready at an edge with no new accept -> rsp_valid <= 0.
  - With a simultaneous accept, the new result replaces the old one; rsp_valid stays 1.
- Backpressure: while rsp_valid=1 and rsp_ready=0, rsp_* hold stable and no accept occurs. rr_ptr is unchanged.
- Fairness: rr_ptr moves only on accept. A continuously valid requester waits at most NREQ-1 accepts.
- Requester rules (checked by the bench):
  - Once req_valid[i] rises, it and its operands stay stable until accepted.
  - req_valid bits for indices >= NREQ are not present.
- Arithmetic: full 32-bit unsigned product, no truncation or sign handling. 16'hFFFF*16'hFFFF = 32'hFFFE0001.

Optional Feature:
- Macro MULT_SHARE_ARB_SKID_EN.
- Defined:
  - Output stage becomes a 2-entry FIFO (skid buffer).
  - slot_free = fifo not full, registered; req_ready has no combinational path from rsp_ready.
  - rsp_* are presented from the FIFO head, in accept order.
  - Latency remains 1 cycle when the FIFO is empty.
  - Simultaneous push and pop when the FIFO holds 1 entry keeps its count at 1.
  - When full (2 entries), req_ready is all zero until a pop.
  - Reset empties the FIFO.
- Undefined: single output register as described above.

Test Plan:
- Reset: hold rst=1 with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, rsp_product=0. After release, first grant goes to requester 0.
- Single request: requester 2 with a=16'd300, b=16'd7, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=2, rsp_product=32'd2100.
- Round robin:
  - All four valid continuously, rsp_ready=1 -> accepts in order 0,1,2,3,0.
  - Operands a=i+1, b=16'hFFFF -> products 32'h0000FFFF, 32'h0001FFFE, 32'h0002FFFD, 32'h0003FFFC.
- Backpressure:
  - rsp_ready=0 for 5 cycles with requesters 1 and 3 valid -> rsp_* stable, req_ready=0, rr_ptr unchanged.
  - Raise rsp_ready -> next accept is the correct round-robin index.
- Boundary arithmetic: a=b=16'hFFFF -> rsp_product=32'hFFFE0001. Also a=0, b=16'hFFFF -> 32'h0.
- Reset mid-operation: assert rst while rsp_valid=1, rsp_ready=0 -> rsp_valid drops immediately (async) and the stale result is never delivered. With MULT_SHARE_ARB_SKID_EN, two queued entries are both discarded.
